// File: rtl/if_fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: FSM encodings, word size, PC step.
package if_fetch_unit_pkg;

  localparam int unsigned InstLen = 32;
  localparam logic [InstLen-1:0] PcInc = 32'd4;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  function automatic logic [InstLen-1:0] word_align(input logic [InstLen-1:0] a);
    return {a[InstLen-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache, one word per line; combinational lookup, registered fill.
module if_icache
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned LINES = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [InstLen-1:0] lookup_addr_i,
  output logic               hit_o,
  output logic [InstLen-1:0] data_o,
  input  logic               fill_en_i,
  input  logic [InstLen-1:0] fill_addr_i,
  input  logic [InstLen-1:0] fill_data_i
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = InstLen - IdxW - 2;

  logic [LINES-1:0]   valid_q;
  logic [TagW-1:0]    tag_q  [LINES];
  logic [InstLen-1:0] data_q [LINES];

  logic [IdxW-1:0] lidx;
  logic [IdxW-1:0] fidx;
  logic            unused_lo;

  assign lidx      = lookup_addr_i[IdxW+1:2];
  assign fidx      = fill_addr_i[IdxW+1:2];
  assign unused_lo = ^{lookup_addr_i[1:0], fill_addr_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fidx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset: valid bits gate every hit.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[fidx]  <= fill_addr_i[InstLen-1:IdxW+2];
      data_q[fidx] <= fill_data_i;
    end
  end

  assign hit_o  = valid_q[lidx] && (tag_q[lidx] == lookup_addr_i[InstLen-1:IdxW+2]);
  assign data_o = data_q[lidx];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC ownership, memory fetch, one-entry output slot, redirect flush.
// Optional I-cache is enabled by defining IF_ICACHE_EN.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_LINES = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               stall_in,
  input  logic               branch_or_not_in,
  input  logic [InstLen-1:0] branch_address_in,
  output logic               fetch_req_out,
  output logic [InstLen-1:0] fetch_addr_out,
  input  logic               fetch_ack_in,
  input  logic [InstLen-1:0] fetch_inst_in,
  output logic               inst_valid_out,
  output logic [InstLen-1:0] inst_out,
  output logic [InstLen-1:0] pc_out
);

  logic [1:0]         state_q, state_d;
  logic [InstLen-1:0] pc_q, pc_d;
  logic               req_q, req_d;
  logic [InstLen-1:0] addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [InstLen-1:0] inst_q, inst_d;
  logic [InstLen-1:0] pco_q, pco_d;
  logic [InstLen-1:0] buf_q, buf_d;

  logic               slot_free;
  logic               ack_mem;
  logic               ack_eff;
  logic [InstLen-1:0] data_eff;
  logic [InstLen-1:0] target;
  logic [InstLen-1:0] next_pc;

  assign slot_free = !valid_q || !stall_in;
  assign ack_mem   = req_q && fetch_ack_in;
  assign target    = word_align(branch_address_in);
  assign next_pc   = pc_q + PcInc;

`ifdef IF_ICACHE_EN
  // With the cache, a new fetch first spends a cycle probing; req is raised only on a miss.
  localparam logic LaunchReq = 1'b0;

  logic               probe_hit;
  logic [InstLen-1:0] probe_data;
  logic               fill_en;

  if_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk_i        (clk_in),
    .rst_ni       (rst_in),
    .lookup_addr_i(pc_q),
    .hit_o        (probe_hit),
    .data_o       (probe_data),
    .fill_en_i    (fill_en),
    .fill_addr_i  (addr_q),
    .fill_data_i  (fetch_inst_in)
  );

  assign fill_en  = rdy_in && !branch_or_not_in && (state_q == S_FETCH) && ack_mem;
  assign ack_eff  = ack_mem || ((state_q == S_FETCH) && !req_q && probe_hit);
  assign data_eff = ack_mem ? fetch_inst_in : probe_data;
`else
  localparam logic LaunchReq = 1'b1;

  logic unused_cfg;

  assign ack_eff    = ack_mem;
  assign data_eff   = fetch_inst_in;
  assign unused_cfg = ^ICACHE_LINES;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    pco_d   = pco_q;
    buf_d   = buf_q;
    if (rdy_in) begin
      if (valid_q && !stall_in) valid_d = 1'b0;
      if (branch_or_not_in) begin
        pc_d    = target;
        valid_d = 1'b0;
        // Only an outstanding, unanswered request forces a drain.
        if (!req_q || ack_mem) begin
          state_d = S_FETCH;
          req_d   = LaunchReq;
          addr_d  = target;
        end else begin
          state_d = S_DRAIN;
        end
      end else begin
        case (state_q)
          S_FETCH: begin
            if (ack_eff) begin
              if (slot_free) begin
                valid_d = 1'b1;
                inst_d  = data_eff;
                pco_d   = pc_q;
                pc_d    = next_pc;
                req_d   = LaunchReq;
                addr_d  = next_pc;
              end else begin
                buf_d   = data_eff;
                state_d = S_HOLD;
                req_d   = 1'b0;
              end
            end else if (!req_q) begin
              req_d  = 1'b1;
              addr_d = pc_q;
            end
          end
          S_HOLD: begin
            if (slot_free) begin
              valid_d = 1'b1;
              inst_d  = buf_q;
              pco_d   = pc_q;
              pc_d    = next_pc;
              state_d = S_FETCH;
              req_d   = LaunchReq;
              addr_d  = next_pc;
            end
          end
          S_DRAIN: begin
            if (ack_mem) begin
              state_d = S_FETCH;
              req_d   = LaunchReq;
              addr_d  = pc_q;
            end
          end
          default: begin
            state_d = S_FETCH;
            req_d   = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      inst_q  <= '0;
      pco_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pco_q   <= pco_d;
      buf_q   <= buf_d;
    end
  end

  assign fetch_req_out  = req_q;
  assign fetch_addr_out = addr_q;
  assign inst_valid_out = valid_q;
  assign inst_out       = inst_q;
  assign pc_out         = pco_q;

endmodule
